// File: rtl/hnf_txreq_sched_if.sv
// hnf_txreq_sched_if: requester handshake and TXREQ link bundle for the HN-F TXREQ scheduler.
// The slave modport is the scheduler side; master is the requesters and link side.
interface hnf_txreq_sched_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned FLIT_W  = 64,
  parameter int unsigned CRDW    = 4
);
  logic [NUM_REQ-1:0][FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]             req_v;
  logic [NUM_REQ-1:0]             req_rdy;
  logic                           link_en;
  logic [FLIT_W-1:0]              txreqflit;
  logic                           txreqflitv;
  logic                           txreqflitpend;
  logic                           txreqlcrdv;
  logic [CRDW-1:0]                crd_cnt;
  logic                           crd_ovf;

  modport master (
    output req_flit, req_v, link_en, txreqlcrdv,
    input  req_rdy, txreqflit, txreqflitv, txreqflitpend, crd_cnt, crd_ovf
  );

  modport slave (
    input  req_flit, req_v, link_en, txreqlcrdv,
    output req_rdy, txreqflit, txreqflitv, txreqflitpend, crd_cnt, crd_ovf
  );
endinterface

// File: rtl/hnf_txreq_sched.sv
// hnf_txreq_sched: shares the HN-F TXREQ channel between NUM_REQ requesters, owns the TXREQ
// L-credit counter and returns all held credits as LCrdReturn flits when the link goes down.
// Build option: define HNF_TXREQ_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default is round-robin arbitration.
module hnf_txreq_sched #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_LCRD = 15,
  parameter int unsigned CRDW     = 4,
  parameter int unsigned FLIT_W   = 64
) (
  input logic               i_clk,
  input logic               i_rst_n,
  hnf_txreq_sched_if.slave  io_bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_d;
  logic [CRDW-1:0]    r_crd_cnt;
  logic [CRDW-1:0]    w_crd_d;
  logic               r_crd_ovf;
  logic               w_ovf_d;
  logic               r_flitv;
  logic [FLIT_W-1:0]  r_flit;
  logic               r_pend;

  logic               w_issue_ok;
  logic               w_gnt_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_req_rdy;
  logic               w_ret;
  logic               w_consume;

`ifndef HNF_TXREQ_FIXED_PRIO_EN
  logic [PTR_W-1:0]   r_rr_ptr;
`endif

  assign w_issue_ok = (r_state == ST_RUN) && (r_crd_cnt != '0);
  // An LCrdReturn goes out every DRAIN cycle that still holds a credit.
  assign w_ret      = (r_state == ST_DRAIN) && (r_crd_cnt != '0);
  assign w_consume  = w_gnt_any || w_ret;

  // Pick the first requesting index, starting from the round-robin pointer (or from 0).
  always_comb begin
    int unsigned w_sum;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_req_rdy = '0;
    w_sum     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef HNF_TXREQ_FIXED_PRIO_EN
      w_sum = k;
`else
      w_sum = 32'(r_rr_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
`endif
      if (!w_gnt_any && io_bus.req_v[PTR_W'(w_sum)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PTR_W'(w_sum);
      end
    end
    w_gnt_any = w_gnt_any && w_issue_ok;
    if (w_gnt_any) w_req_rdy[w_gnt_idx] = 1'b1;
  end

  // Credit count: arrival and consume in one cycle cancel; saturate and flag at MAX_LCRD.
  always_comb begin
    w_crd_d = r_crd_cnt;
    w_ovf_d = r_crd_ovf;
    if (io_bus.txreqlcrdv && !w_consume) begin
      if (r_crd_cnt == CRDW'(MAX_LCRD)) w_ovf_d = 1'b1;
      else                              w_crd_d = r_crd_cnt + CRDW'(1);
    end else if (!io_bus.txreqlcrdv && w_consume) begin
      w_crd_d = r_crd_cnt - CRDW'(1);
    end
  end

  // Link state: DRAIN ignores link_en until every credit, including late arrivals, is returned.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_STOP:  if (io_bus.link_en)  w_state_d = ST_RUN;
      ST_RUN:   if (!io_bus.link_en) w_state_d = ST_DRAIN;
      ST_DRAIN: if ((r_crd_cnt == '0) && !io_bus.txreqlcrdv) w_state_d = ST_STOP;
      default:  w_state_d = ST_STOP;
    endcase
  end

  // State, credits and the registered TXREQ output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_STOP;
      r_crd_cnt <= '0;
      r_crd_ovf <= 1'b0;
      r_flitv   <= 1'b0;
      r_flit    <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_crd_cnt <= w_crd_d;
      r_crd_ovf <= w_ovf_d;
      r_pend    <= (w_state_d != ST_STOP);
      if (w_gnt_any) begin
        r_flitv <= 1'b1;
        r_flit  <= io_bus.req_flit[w_gnt_idx];
      end else if (w_ret) begin
        // LCrdReturn: all-zero flit, opcode 0x00.
        r_flitv <= 1'b1;
        r_flit  <= '0;
      end else begin
        r_flitv <= 1'b0;
      end
    end
  end

`ifndef HNF_TXREQ_FIXED_PRIO_EN
  // Round-robin pointer moves to just past the last winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end
`endif

  assign io_bus.req_rdy       = w_req_rdy;
  assign io_bus.txreqflit     = r_flit;
  assign io_bus.txreqflitv    = r_flitv;
  assign io_bus.txreqflitpend = r_pend;
  assign io_bus.crd_cnt       = r_crd_cnt;
  assign io_bus.crd_ovf       = r_crd_ovf;

endmodule

// File: tb/tb_hnf_txreq_sched.sv
// tb_hnf_txreq_sched: vector table, directed corner sequences and a randomized run against a
// behavioural model of the TXREQ scheduler.
module tb_hnf_txreq_sched;
  localparam int unsigned NR   = 2;
  localparam int unsigned MAXL = 15;
  localparam int unsigned CW   = 4;
  localparam int unsigned FW   = 64;
`ifdef HNF_TXREQ_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [63:0] F0 = 64'hA0A0_0000_0000_0001;
  localparam logic [63:0] F1 = 64'hB1B1_0000_0000_0002;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hnf_txreq_sched_if #(.NUM_REQ(NR), .FLIT_W(FW), .CRDW(CW)) bus ();

  hnf_txreq_sched #(.NUM_REQ(NR), .MAX_LCRD(MAXL), .CRDW(CW), .FLIT_W(FW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit le, input logic [1:0] rv, input bit lc);
    bus.link_en    = le;
    bus.req_v      = rv;
    bus.txreqlcrdv = lc;
  endtask

  task automatic do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          le;
    logic [1:0]  rv;
    bit          lc;
    logic [1:0]  rdy;
    bit          fv;
    logic [63:0] fl;
    logic [3:0]  cnt;
    bit          pend;
  } vec_t;

  vec_t vt[18];

  // Reference model state
  int          m_state, m_cnt, m_ptr, m_old, g;
  bit          m_ovf, m_fv, le_r, lc_r, ret;
  logic [63:0] m_fl;
  bit          pv[NR];
  logic [63:0] pf[NR];
  logic [1:0]  exp_rdy;

  initial begin
    logic [7:0]  fv_mask, pend_mask, rdy_seen;
    logic [63:0] flit_or;

    bus.req_flit[0] = F0;
    bus.req_flit[1] = F1;
    do_reset();

    // Reset values
    #1;
    chk("rst_flitv", 64'(bus.txreqflitv), 64'd0);
    chk("rst_flit", bus.txreqflit, 64'd0);
    chk("rst_pend", 64'(bus.txreqflitpend), 64'd0);
    chk("rst_cnt", 64'(bus.crd_cnt), 64'd0);
    chk("rst_ovf", 64'(bus.crd_ovf), 64'd0);
    chk("rst_rdy", 64'(bus.req_rdy), 64'd0);
    @(negedge clk);

    // Vector table: bring-up, 3 credits, 3 grants, then 3 credits drained on link down
    vt[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 4'd0, 1'b0};
    vt[1]  = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd0, 1'b1};
    vt[2]  = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd1, 1'b1};
    vt[3]  = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd2, 1'b1};
    vt[4]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 64'h0, 4'd3, 1'b1};
    vt[5]  = '{1'b1, 2'b11, 1'b0, FIXED ? 2'b01 : 2'b10, 1'b1, F0, 4'd2, 1'b1};
    vt[6]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, FIXED ? F0 : F1, 4'd1, 1'b1};
    vt[7]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b1, F0, 4'd0, 1'b1};
    vt[8]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 4'd0, 1'b1};
    vt[9]  = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd0, 1'b1};
    vt[10] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd1, 1'b1};
    vt[11] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'h0, 4'd2, 1'b1};
    vt[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 4'd3, 1'b1};
    vt[13] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 64'h0, 4'd3, 1'b1};
    vt[14] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 64'h0, 4'd2, 1'b1};
    vt[15] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 64'h0, 4'd1, 1'b1};
    vt[16] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 64'h0, 4'd0, 1'b1};
    vt[17] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 4'd0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      set_in(vt[i].le, vt[i].rv, vt[i].lc);
      #1;
      chk($sformatf("vec%0d_rdy", i), 64'(bus.req_rdy), 64'(vt[i].rdy));
      chk($sformatf("vec%0d_flitv", i), 64'(bus.txreqflitv), 64'(vt[i].fv));
      if (vt[i].fv) chk($sformatf("vec%0d_flit", i), bus.txreqflit, vt[i].fl);
      chk($sformatf("vec%0d_cnt", i), 64'(bus.crd_cnt), 64'(vt[i].cnt));
      chk($sformatf("vec%0d_pend", i), 64'(bus.txreqflitpend), 64'(vt[i].pend));
      tick();
    end

    // Credit arrival and grant in the same cycle
    do_reset();
    set_in(1'b1, 2'b00, 1'b0);
    tick();
    set_in(1'b1, 2'b00, 1'b1);
    tick();
    set_in(1'b1, 2'b01, 1'b1);
    #1;
    chk("same_rdy", 64'(bus.req_rdy), 64'd1);
    chk("same_cnt_before", 64'(bus.crd_cnt), 64'd1);
    tick();
    set_in(1'b1, 2'b00, 1'b0);
    #1;
    chk("same_cnt_after", 64'(bus.crd_cnt), 64'd1);
    chk("same_flitv", 64'(bus.txreqflitv), 64'd1);
    chk("same_flit", bus.txreqflit, F0);
    tick();

    // Overflow at MAX_LCRD, sticky until reset
    do_reset();
    set_in(1'b1, 2'b00, 1'b1);
    repeat (15) tick();
    #1;
    chk("ovf_cnt15", 64'(bus.crd_cnt), 64'd15);
    chk("ovf_pre", 64'(bus.crd_ovf), 64'd0);
    tick();
    set_in(1'b1, 2'b00, 1'b0);
    #1;
    chk("ovf_cnt_hold", 64'(bus.crd_cnt), 64'd15);
    chk("ovf_set", 64'(bus.crd_ovf), 64'd1);
    repeat (3) tick();
    set_in(1'b1, 2'b01, 1'b0);
    tick();
    set_in(1'b1, 2'b00, 1'b0);
    #1;
    chk("ovf_sticky", 64'(bus.crd_ovf), 64'd1);
    chk("ovf_cnt14", 64'(bus.crd_cnt), 64'd14);
    tick();

    // DRAIN at 2 credits with one late credit and link_en re-asserted
    do_reset();
    set_in(1'b1, 2'b00, 1'b1);
    tick();
    tick();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    #1;
    chk("drn_cnt2", 64'(bus.crd_cnt), 64'd2);
    fv_mask   = '0;
    pend_mask = '0;
    rdy_seen  = '0;
    flit_or   = '0;
    for (int c = 0; c < 8; c++) begin
      set_in(1'b1, 2'b11, (c == 0));
      #1;
      fv_mask[c]   = bus.txreqflitv;
      pend_mask[c] = bus.txreqflitpend;
      rdy_seen[c]  = |bus.req_rdy;
      if (bus.txreqflitv) flit_or = flit_or | bus.txreqflit;
      tick();
    end
    chk("drn_flitv_seq", 64'(fv_mask), 64'h0E);
    chk("drn_pend_seq", 64'(pend_mask), 64'hEF);
    chk("drn_rdy_none", 64'(rdy_seen), 64'h00);
    chk("drn_lcrdreturn", flit_or, 64'h0);

    // Four grants with both requesters held
    do_reset();
    set_in(1'b1, 2'b00, 1'b1);
    repeat (4) tick();
    set_in(1'b1, 2'b11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb%0d_rdy", k), 64'(bus.req_rdy),
          (FIXED || (k % 2 == 0)) ? 64'd1 : 64'd2);
      tick();
    end
    #1;
    chk("arb_rdy_empty", 64'(bus.req_rdy), 64'd0);
    chk("arb_cnt0", 64'(bus.crd_cnt), 64'd0);
    chk("arb_flitv", 64'(bus.txreqflitv), 64'd1);

    // Asynchronous reset drops the in-flight flit immediately
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flitv", 64'(bus.txreqflitv), 64'd0);
    chk("mid_rst_flit", bus.txreqflit, 64'd0);
    chk("mid_rst_pend", 64'(bus.txreqflitpend), 64'd0);
    chk("mid_rst_rdy", 64'(bus.req_rdy), 64'd0);
    @(negedge clk);
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    rst_n = 1'b1;

    // Randomized run against the model
    m_state = 0; m_cnt = 0; m_ptr = 0; m_ovf = 1'b0; m_fv = 1'b0; m_fl = '0;
    le_r = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0;
      pf[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pf[i] = {$urandom, $urandom};
        end
        bus.req_flit[i] = pf[i];
        bus.req_v[i]    = pv[i];
      end
      if ($urandom_range(0, 24) == 0) le_r = !le_r;
      lc_r = ($urandom_range(0, 2) == 0);
      bus.link_en    = le_r;
      bus.txreqlcrdv = lc_r;
      #1;
      g = -1;
      if (m_state == 1 && m_cnt > 0) begin
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (m_ptr + k) % NR;
          if (g < 0 && pv[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      chk("rnd_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
      chk("rnd_flitv", 64'(bus.txreqflitv), 64'(m_fv));
      if (m_fv) chk("rnd_flit", bus.txreqflit, m_fl);
      chk("rnd_cnt", 64'(bus.crd_cnt), 64'(m_cnt));
      chk("rnd_ovf", 64'(bus.crd_ovf), 64'(m_ovf));
      chk("rnd_pend", 64'(bus.txreqflitpend), 64'(m_state != 0));
      // Advance the model by one clock
      m_old = m_cnt;
      ret   = (m_state == 2) && (m_cnt > 0);
      m_cnt = m_cnt + int'(lc_r) - int'((g >= 0) || ret);
      if (m_cnt > int'(MAXL)) begin
        m_cnt = MAXL;
        m_ovf = 1'b1;
      end
      m_fv = (g >= 0) || ret;
      if (g >= 0) m_fl = pf[g];
      else if (ret) m_fl = '0;
      if (g >= 0) begin
        pv[g] = 1'b0;
        if (!FIXED) m_ptr = (g + 1) % NR;
      end
      case (m_state)
        0: if (le_r) m_state = 1;
        1: if (!le_r) m_state = 2;
        default: if (m_old == 0 && !lc_r) m_state = 0;
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
